// File: rtl/systolic_pq_cell.sv
// One storage cell of a linear systolic min-priority queue, plus the stable
// three-entry sorter it uses to merge an incoming entry with its stored pair.

module systolic_pq_sort3 #(
  parameter int unsigned KW = 8,
  parameter int unsigned VW = 4
) (
  input  logic [KW+VW-1:0] a,
  input  logic [KW+VW-1:0] b,
  input  logic [KW+VW-1:0] c,
  output logic [KW+VW-1:0] minv,
  output logic [KW+VW-1:0] medv,
  output logic [KW+VW-1:0] maxv
);
  logic [KW+VW-1:0] w_x0, w_x1, w_y1, w_y2;

  // Adjacent compare-swaps on strict key order keep equal keys in a,b,c order.
  always_comb begin
    w_x0 = a;
    w_x1 = b;
    if (a[KW+VW-1:VW] > b[KW+VW-1:VW]) begin
      w_x0 = b;
      w_x1 = a;
    end
    w_y1 = w_x1;
    w_y2 = c;
    if (w_x1[KW+VW-1:VW] > c[KW+VW-1:VW]) begin
      w_y1 = c;
      w_y2 = w_x1;
    end
    minv = w_x0;
    medv = w_y1;
    if (w_x0[KW+VW-1:VW] > w_y1[KW+VW-1:VW]) begin
      minv = w_y1;
      medv = w_x0;
    end
    maxv = w_y2;
  end
endmodule

module systolic_pq_cell #(
  parameter int unsigned KW = 8,
  parameter int unsigned VW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       op_in,
  input  logic [KW+VW-1:0] din,
  output logic             ready_out,
  output logic [1:0]       op_out,
  output logic [KW+VW-1:0] dout,
  output logic [KW+VW-1:0] ret_out,
  input  logic [KW+VW-1:0] ret_in,
  output logic [KW+VW-1:0] hi_out,
  output logic             empty_out,
  output logic             protocol_err
);
  localparam int unsigned EW = KW + VW;
  localparam logic [EW-1:0] EMPTY = {{KW{1'b1}}, {VW{1'b0}}};

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_INS = 2'b01,
    OP_EXT = 2'b10,
    OP_RSV = 2'b11
  } op_t;

  logic [EW-1:0] r_lo, r_hi, r_dout;
  op_t           r_op;
  logic          r_fill, r_perr;

  logic          w_ins, w_ext, w_hi_empty, w_max_empty;
  logic [EW-1:0] w_c, w_min, w_med, w_max;

  assign w_ins       = (op_in == OP_INS) && (din[EW-1:VW] != '1);
  assign w_ext       = (op_in == OP_EXT);
  assign w_hi_empty  = (r_hi[EW-1:VW] == '1);
  assign w_max_empty = (w_max[EW-1:VW] == '1);
  // The sorter's third operand is the right neighbour's head during a fill.
  assign w_c         = r_fill ? ret_in : din;

  systolic_pq_sort3 #(.KW(KW), .VW(VW)) u_sort3 (
    .a    (r_lo),
    .b    (r_hi),
    .c    (w_c),
    .minv (w_min),
    .medv (w_med),
    .maxv (w_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo   <= EMPTY;
      r_hi   <= EMPTY;
      r_dout <= EMPTY;
      r_op   <= OP_NOP;
      r_fill <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      r_op   <= OP_NOP;
      r_dout <= EMPTY;
      if (r_fill) begin
        r_lo   <= w_min;
        r_hi   <= w_med;
        r_fill <= 1'b0;
        if (w_ins || w_ext) r_perr <= 1'b1;
      end else if (w_ins) begin
        r_lo <= w_min;
        r_hi <= w_med;
        if (!w_max_empty) begin
          r_op   <= OP_INS;
          r_dout <= w_max;
        end
      end else if (w_ext) begin
        if (w_hi_empty) begin
          r_lo <= EMPTY;
        end else begin
          r_lo   <= r_hi;
          r_hi   <= EMPTY;
          r_op   <= OP_EXT;
          r_fill <= 1'b1;
        end
      end
    end
  end

  assign ready_out    = !r_fill;
  assign op_out       = r_op;
  assign dout         = r_dout;
  assign ret_out      = r_lo;
  assign hi_out       = r_hi;
  assign empty_out    = (r_lo[EW-1:VW] == '1);
  assign protocol_err = r_perr;
endmodule

// File: doc/systolic_pq_cell.md
Name: systolic_pq_cell

Overview:
- One storage cell of the linear systolic min-priority queue. Each cell holds two key/value entries, lo and hi, with lo <= hi.
- On every cycle the cell instantiates systolic_pq_sort3 and combines the incoming operand with its stored pair. It keeps the two smallest entries and forwards the operation to its right neighbour one cycle later.
- The cell directly consumes sort3's minv/medv/maxv outputs. Cells are chained: op_out/dout feed the next cell's op_in/din, and that cell's ret_out feeds this cell's ret_in.

Parameters:
- KW, 8, key width; a smaller key means higher priority.
- VW, 4, value (tag) width.
- Entry format: {key[KW-1:0], value[VW-1:0]}, width KW+VW.
- EMPTY entry: key all-ones, value zero. An entry with an all-ones key is an empty slot.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- op_in  in  2  opcode: 00 NOP, 01 INS, 10 EXT, 11 reserved (treated as NOP)
- din  in  KW+VW  entry to insert, valid with INS
- ready_out  out  1  cell can accept a non-NOP op this cycle
- op_out  out  2  registered op forwarded to the right cell
- dout  out  KW+VW  registered entry forwarded with op_out
- ret_out  out  KW+VW  current lo entry, wired to the left cell's ret_in (or to the queue head output)
- ret_in  in  KW+VW  right cell's ret_out; tie to EMPTY on the last cell
- hi_out  out  KW+VW  current hi entry, for debug/occupancy
- empty_out  out  1  lo key is all-ones
- protocol_err  out  1  sticky flag; clears only on reset

Behaviour:
- Reset (asynchronous, active-low):
  - lo = hi = EMPTY, dout = EMPTY, op_out = NOP.
  - fill_pending = 0, protocol_err = 0.
  - Hence ready_out = 1 and empty_out = 1.
- ready_out = !fill_pending.
- INS (din key != all-ones, ready_out = 1):
  - sort3(a = lo, b = hi, c = din) → lo <= minv, hi <= medv.
  - Next cycle: op_out = INS and dout = maxv if maxv key != all-ones; otherwise op_out = NOP, dout = EMPTY.
  - Ties: stored entries precede the incoming entry among equal keys, so FIFO order holds for equal keys. Ties between lo and hi keep lo first.
- INS with an all-ones din key is treated as NOP.
- EXT, ready_out = 1:
  - The left consumer samples ret_out (old lo) in this cycle.
  - hi empty: lo <= EMPTY, op_out <= NOP, no fill.
  - hi occupied: lo <= hi, hi <= EMPTY, op_out <= EXT, dout <= EMPTY, fill_pending <= 1.
- Fill cycle (the cycle after a forwarded EXT, fill_pending = 1):
  - sort3(lo, hi, ret_in) → lo <= minv, hi <= medv; maxv is discarded (it is EMPTY by invariant).
  - op_out <= NOP; fill_pending <= 0.
- NOP: state unchanged; op_out <= NOP, dout <= EMPTY.
- Non-NOP op_in while ready_out = 0: the op is ignored, state is unaffected and protocol_err <= 1.
- Invariants the cell maintains:
  - lo.key <= hi.key.
  - Every entry in cells to the right has key >= hi.key.
  - Slots fill left to right: hi empty implies all right cells are empty.
- Latency:
  - Op forwarding: 1 cycle per cell.
  - ret_out is combinational from the lo register, with no added latency.
  - EXT occupies the cell for 2 cycles.
- Queue head issue rule: at most one non-NOP op every 2 cycles, which guarantees no cell downstream ever sees an op during its fill.
- Overflow: the last cell's op_out = INS means the queue has dropped that entry; detecting and reporting it is the top level's responsibility.

Test Plan (KW=8, VW=4; single cell, bench drives ret_in and acts as the right neighbour):
- Reset, then check: lo = hi = dout = 12'hff0, op_out = 00, ready_out = 1, empty_out = 1. Assert rst_n mid-fill → all state returns to reset values immediately, without waiting for a clock edge.
- INS 12'h03a, 12'h01b, 12'h02c at 2-cycle spacing:
  - Expect lo = 12'h01b, hi = 12'h02c.
  - The third insert forwards op_out = INS, dout = 12'h03a one cycle later.
  - The first two inserts forward NOP.
- From lo = 12'h01b, hi = 12'h02c, ret_in = 12'h03a, issue EXT:
  - ret_out = 12'h01b in the EXT cycle.
  - Next cycle: op_out = EXT, ready_out = 0.
  - After the fill: lo = 12'h02c, hi = 12'h03a, ready_out = 1.
- Ties: INS 12'h11a, 12'h11b, 12'h11c → lo = 12'h11a, hi = 12'h11b, dout = 12'h11c. Then EXT yields ret_out = 12'h11a.
- EXT on an empty cell → ret_out = 12'hff0, op_out = NOP, no fill, ready_out stays 1. INS 12'hff5 → treated as NOP, state unchanged.
- INS issued while ready_out = 0 (cycle after a forwarded EXT) → state unchanged and protocol_err = 1, staying set until reset.
